emul_sram_2p: RTL
=================

Name: emul_sram_2p

Overview:
- Parametrised single-clock, one-read-port / one-write-port SRAM model for Xilinx emulation of the core-v-mcu macro memories.
- Generalises the fixed 512x64 emulation RAM in three ways: configurable width and depth, a per-byte write enable, and an optional address-fold mode that halves BRAM usage by storing the top half of the address space inverted.
- Adds a power-mode state machine with deep-sleep, power-gate, scrub and wake behaviour, so software power sequences can be exercised on FPGA.

Parameters:
- DATA_W, 64, word width in bits; must be a multiple of 8.
- DEPTH, 512, logical words; must be a power of two, minimum 4.
- FOLD, 1, 1 = physical depth is DEPTH/2 and the upper half is stored inverted (aliased); 0 = full physical depth.
- WAKE_CYC, 4, cycles spent in WAKE before ACTIVE; range 1..255.
- POISON, 64'hDEAD_BEEF_DEAD_BEEF, raw pattern written by the scrub, truncated to DATA_W.

Ports:
- clk_i  in  1  single clock for both ports.
- rst_ni  in  1  asynchronous active-low reset.
- cen_r_ni  in  1  read enable, active low.
- addr_r_i  in  $clog2(DEPTH)  read address.
- cen_w_ni  in  1  write enable, active low.
- addr_w_i  in  $clog2(DEPTH)  write address.
- wdata_i  in  DATA_W  write data.
- be_i  in  DATA_W/8  byte enables, 1 = write that byte.
- deepsleep_i  in  1  retention sleep request.
- powergate_i  in  1  power-off request.
- q_o  out  DATA_W  read data, registered.
- rvalid_o  out  1  pulses high the cycle q_o updates.
- ready_o  out  1  high only in ACTIVE.

Behaviour:
- Reset (asynchronous, active low):
  - State goes to SCRUB, scrub counter = 0.
  - q_o = 0, rvalid_o = 0, ready_o = 0.
  - Memory contents are not reset directly; SCRUB defines them after reset.
- Physical row and inversion:
  - FOLD=1: physical row = addr[MSB-1:0]; inv = addr[MSB].
  - FOLD=0: physical row = full address; inv = 0.
- Write, ACTIVE only, cen_w_ni=0:
  - For each byte b with be_i[b]=1: row byte b <= inv ? ~wdata byte : wdata byte.
  - Bytes with be_i[b]=0 keep their old value.
  - be_i=0 is a legal no-op.
- Read, ACTIVE only, cen_r_ni=0:
  - Latency 1: q_o <= inv ? ~row : row, and rvalid_o=1 in the following cycle.
  - When no read is accepted, q_o holds its value and rvalid_o=0.
- Read and write to the same physical row in the same cycle: read-first, so q_o returns the pre-write contents (see WR_BYPASS_EN).
- FOLD=1 aliasing: addr A and A+DEPTH/2 share one row; the upper address reads the bitwise inverse of the lower. This is intended model behaviour.
- Outside ACTIVE: cen_r_ni and cen_w_ni are ignored, rvalid_o=0, q_o holds its last value (except OFF).
- Power FSM; evaluation order per cycle: powergate_i, then deepsleep_i, then counters.
  - ACTIVE:
    - powergate_i=1 -> OFF.
    - else deepsleep_i=1 -> SLEEP.
    - A request in the same cycle as the transition is still serviced.
  - SLEEP: contents retained.
    - powergate_i=1 -> OFF.
    - deepsleep_i=0 -> WAKE.
  - OFF: q_o <= POISON each cycle; contents considered lost.
    - powergate_i=0 -> SCRUB.
  - SCRUB: writes raw POISON to physical row = counter, increments by 1 per cycle over PHYS_DEPTH rows.
    - Last row written -> WAKE.
    - powergate_i=1 -> OFF, counter cleared.
    - deepsleep_i is ignored in this state.
  - WAKE: counts WAKE_CYC cycles, then -> ACTIVE.
    - powergate_i=1 -> OFF.
    - deepsleep_i=1 -> SLEEP, counter cleared.
- ready_o is registered and equals (state==ACTIVE).
- Logical reads after a scrub return POISON for the lower half and ~POISON for the upper half when FOLD=1.
- Reset asserted mid-SCRUB or mid-WAKE restarts SCRUB from row 0.

Optional Feature:
- Macro: EMUL_SRAM_WR_BYPASS_EN.
- Defined: a same-cycle read and write to the same logical address returns write-first data. Bytes with be_i=1 come from wdata_i, others from old contents. Aliased (inverted-address) collisions are also forwarded, with inversion applied.
- Undefined: read-first, as in Behaviour. No forwarding logic is synthesised.

Decomposition:
- Package emul_sram_pkg contains:
  - typedef enum logic [2:0] pwr_state_e {PWR_ACTIVE, PWR_SLEEP, PWR_OFF, PWR_SCRUB, PWR_WAKE}.
  - Localparam defaults for DATA_W, DEPTH and POISON.
  - Function phys_depth(DEPTH, FOLD).
- Sub-module emul_sram_pwr_fsm (clk_i, rst_ni, deepsleep_i, powergate_i, PHYS_DEPTH, WAKE_CYC):
  - Owns the state, scrub counter and wake counter.
  - Outputs state, scrub_we, scrub_row and ready.
  - The top level owns the storage array and the datapath.

Test Plan:
- Reset, then hold idle: ready_o=0 for DEPTH/2+WAKE_CYC cycles (260 at defaults), then 1. Read addr 0x005 -> q_o=0xDEADBEEFDEADBEEF; read addr 0x105 -> q_o=0x2152411021524110.
- Write addr 0x010 data 0x0123456789ABCDEF with be_i=0xFF, then be_i=0x01 data 0xFF..FF. Read addr 0x010 -> 0x01234567_89ABCDFF; read addr 0x110 -> 0xFEDCBA98_76543200.
- Same-cycle read and write of addr 0x020 (old value 0x0, new value 0x55..55) -> q_o=0x0 with the macro undefined, 0x55..55 with the macro defined. rvalid_o=1 in the next cycle in both cases.
- ACTIVE, deepsleep_i=1 for 10 cycles with cen_w_ni=0 driven -> ready_o=0, no writes land. Deassert deepsleep_i -> ready_o returns after WAKE_CYC cycles; prior data intact.
- powergate_i pulse mid-WAKE -> OFF with q_o=POISON. Release -> full SCRUB restarts from row 0. A write made before the power-gate reads back as POISON.
- Assert rst_ni low at SCRUB row 100 -> SCRUB restarts at row 0; rvalid_o=0 and q_o=0 during reset.

Source files
------------

// File: rtl/emul_sram_pkg.sv
// Shared types and defaults for the emulation SRAM model.
// Optional write-first forwarding is enabled with EMUL_SRAM_WR_BYPASS_EN.
package emul_sram_pkg;

   localparam int          DEF_DATA_W = 64;
   localparam int          DEF_DEPTH  = 512;
   localparam logic [63:0] DEF_POISON = 64'hDEAD_BEEF_DEAD_BEEF;

   typedef enum logic [2:0] {
      PWR_ACTIVE,
      PWR_SLEEP,
      PWR_OFF,
      PWR_SCRUB,
      PWR_WAKE
   } pwr_state_e;

   // Folding keeps only the lower half physically; the upper half aliases it inverted.
   function automatic int phys_depth(input int depth, input int fold);
      return (fold != 0) ? depth / 2 : depth;
   endfunction

endpackage

// File: rtl/emul_sram_pwr_fsm.sv
// Power-mode sequencer: ACTIVE/SLEEP/OFF/SCRUB/WAKE with scrub row and wake counters.
module emul_sram_pwr_fsm
   import emul_sram_pkg::*;
#(
   parameter int PHYS_DEPTH = 256,
   parameter int WAKE_CYC   = 4,
   localparam int RW        = $clog2(PHYS_DEPTH)
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          deepsleep_i,
   input  logic          powergate_i,
   output pwr_state_e    state_o,
   output logic          scrub_we_o,
   output logic [RW-1:0] scrub_row_o,
   output logic          ready_o
);

   pwr_state_e    state_q, state_d;
   logic [RW-1:0] scnt_q, scnt_d;
   logic [7:0]    wcnt_q, wcnt_d;
   logic          ready_q;

   // Priority inside each state: powergate first, then deepsleep, then counters.
   always_comb begin
      state_d = state_q;
      scnt_d  = scnt_q;
      wcnt_d  = wcnt_q;
      case (state_q)
         PWR_ACTIVE: begin
            if (powergate_i)      state_d = PWR_OFF;
            else if (deepsleep_i) state_d = PWR_SLEEP;
         end
         PWR_SLEEP: begin
            if (powergate_i) state_d = PWR_OFF;
            else if (!deepsleep_i) begin
               state_d = PWR_WAKE;
               wcnt_d  = '0;
            end
         end
         PWR_OFF: begin
            scnt_d = '0;
            if (!powergate_i) state_d = PWR_SCRUB;
         end
         PWR_SCRUB: begin
            if (powergate_i) begin
               state_d = PWR_OFF;
               scnt_d  = '0;
            end else if (scnt_q == RW'(PHYS_DEPTH - 1)) begin
               state_d = PWR_WAKE;
               scnt_d  = '0;
               wcnt_d  = '0;
            end else begin
               scnt_d = scnt_q + 1'b1;
            end
         end
         PWR_WAKE: begin
            if (powergate_i) state_d = PWR_OFF;
            else if (deepsleep_i) begin
               state_d = PWR_SLEEP;
               wcnt_d  = '0;
            end else if (wcnt_q == 8'(WAKE_CYC - 1)) begin
               state_d = PWR_ACTIVE;
            end else begin
               wcnt_d = wcnt_q + 8'd1;
            end
         end
         default: begin
            state_d = PWR_SCRUB;
            scnt_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= PWR_SCRUB;
         scnt_q  <= '0;
         wcnt_q  <= '0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         scnt_q  <= scnt_d;
         wcnt_q  <= wcnt_d;
         ready_q <= (state_d == PWR_ACTIVE);
      end
   end

   assign state_o     = state_q;
   assign scrub_we_o  = (state_q == PWR_SCRUB);
   assign scrub_row_o = scnt_q;
   assign ready_o     = ready_q;

endmodule

// File: rtl/emul_sram_2p.sv
// 1R1W emulation SRAM with byte enables, optional folded storage and power FSM.
// Define EMUL_SRAM_WR_BYPASS_EN for write-first same-row collisions.
module emul_sram_2p
   import emul_sram_pkg::*;
#(
   parameter int          DATA_W   = DEF_DATA_W,
   parameter int          DEPTH    = DEF_DEPTH,
   parameter int          FOLD     = 1,
   parameter int          WAKE_CYC = 4,
   parameter logic [63:0] POISON   = DEF_POISON
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     cen_r_ni,
   input  logic [$clog2(DEPTH)-1:0] addr_r_i,
   input  logic                     cen_w_ni,
   input  logic [$clog2(DEPTH)-1:0] addr_w_i,
   input  logic [DATA_W-1:0]        wdata_i,
   input  logic [DATA_W/8-1:0]      be_i,
   input  logic                     deepsleep_i,
   input  logic                     powergate_i,
   output logic [DATA_W-1:0]        q_o,
   output logic                     rvalid_o,
   output logic                     ready_o
);

   localparam int              AW       = $clog2(DEPTH);
   localparam int              PD       = phys_depth(DEPTH, FOLD);
   localparam int              RW       = $clog2(PD);
   localparam int              NB       = DATA_W / 8;
   localparam logic [DATA_W-1:0] POISON_W = DATA_W'(POISON);

   pwr_state_e    state;
   logic          scrub_we;
   logic [RW-1:0] scrub_row;

   emul_sram_pwr_fsm #(
      .PHYS_DEPTH (PD),
      .WAKE_CYC   (WAKE_CYC)
   ) u_pwr (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .deepsleep_i (deepsleep_i),
      .powergate_i (powergate_i),
      .state_o     (state),
      .scrub_we_o  (scrub_we),
      .scrub_row_o (scrub_row),
      .ready_o     (ready_o)
   );

   logic [DATA_W-1:0] mem [PD];

   logic              active, rd_en, wr_en, inv_r, inv_w;
   logic [RW-1:0]     row_r, row_w;
   logic [DATA_W-1:0] wstore, raw_r, fwd_r, rd_word;

   assign active = (state == PWR_ACTIVE);
   assign rd_en  = active && !cen_r_ni;
   assign wr_en  = active && !cen_w_ni;

   // With FOLD=0, RW==AW so the row is the whole address and the MSB term is masked off.
   assign row_r  = addr_r_i[RW-1:0];
   assign row_w  = addr_w_i[RW-1:0];
   assign inv_r  = (FOLD != 0) && addr_r_i[AW-1];
   assign inv_w  = (FOLD != 0) && addr_w_i[AW-1];
   assign wstore = inv_w ? ~wdata_i : wdata_i;

   always_ff @(posedge clk_i) begin
      if (scrub_we) begin
         mem[scrub_row] <= POISON_W;
      end else if (wr_en) begin
         for (int b = 0; b < NB; b++)
            if (be_i[b]) mem[row_w][b*8 +: 8] <= wstore[b*8 +: 8];
      end
   end

   assign raw_r = mem[row_r];

`ifdef EMUL_SRAM_WR_BYPASS_EN
   // Forward in the stored (physical) domain so aliased collisions invert correctly.
   always_comb begin
      fwd_r = raw_r;
      if (wr_en && (row_w == row_r))
         for (int b = 0; b < NB; b++)
            if (be_i[b]) fwd_r[b*8 +: 8] = wstore[b*8 +: 8];
   end
`else
   assign fwd_r = raw_r;
`endif

   assign rd_word = inv_r ? ~fwd_r : fwd_r;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         q_o      <= '0;
         rvalid_o <= 1'b0;
      end else begin
         rvalid_o <= rd_en;
         if (state == PWR_OFF) q_o <= POISON_W;
         else if (rd_en)       q_o <= rd_word;
      end
   end

endmodule
